// File: rtl/rx_frame_parser_if.sv
// Receive-side bus of rx_frame_parser: word stream in, latched frame fields, start strobe
// and statistics out.
//   master : frame source / reward block side (drives rx_valid, rx_data, done_reward)
//   slave  : parser side (drives rx_ready, en, f* fields, frames_ok, frames_bad)
interface rx_frame_parser_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  rx_valid;
  logic [WORD_WIDTH-1:0] rx_data;
  logic                  rx_ready;
  logic                  done_reward;
  logic                  en;
  logic [WORD_WIDTH-1:0] fsourceID;
  logic [WORD_WIDTH-1:0] fbatteryStat;
  logic [WORD_WIDTH-1:0] fValue;
  logic [WORD_WIDTH-1:0] fclusterID;
  logic [WORD_WIDTH-1:0] fdestinationID;
  logic [CNT_WIDTH-1:0]  frames_ok;
  logic [CNT_WIDTH-1:0]  frames_bad;

  modport master (
    output rx_valid, rx_data, done_reward,
    input  rx_ready, en, fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID,
    input  frames_ok, frames_bad
  );

  modport slave (
    input  rx_valid, rx_data, done_reward,
    output rx_ready, en, fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID,
    output frames_ok, frames_bad
  );
endinterface

// File: rtl/rx_frame_parser.sv
// Word-serial receive front end for the reward datapath. Hunts SYNC_WORD, collects the
// five field words plus an XOR checksum, checks checksum and cluster, then latches the
// fields and pulses en for one cycle. Input is held off until done_reward.
// Ports:
//   clock : system clock, rising edge
//   rst   : asynchronous reset, active-high
//   bus   : rx_frame_parser_if.slave (rx_valid/rx_data/rx_ready handshake, done_reward,
//           en strobe, latched fields, frames_ok/frames_bad saturating counters)
module rx_frame_parser #(
  parameter int unsigned           WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] SYNC_WORD  = 16'hA5A5,
  parameter int unsigned           MY_CLUSTER = 1,
  parameter int unsigned           TIMEOUT    = 64,
  parameter int unsigned           CNT_WIDTH  = 8
) (
  input logic              clock,
  input logic              rst,
  rx_frame_parser_if.slave bus
);

  localparam int unsigned           GapW      = $clog2(TIMEOUT);
  localparam logic [GapW-1:0]       GapLast   = GapW'(TIMEOUT - 1);
  localparam logic [WORD_WIDTH-1:0] MyCluster = WORD_WIDTH'(MY_CLUSTER);
  localparam logic [2:0]            ChkIdx    = 3'd5;

  typedef enum logic [2:0] {StHunt, StFields, StCheck, StIssue, StWaitDone} state_e;

  state_e                state_q, state_d;
  logic                  live_q;
  logic [2:0]            idx_q, idx_d;
  logic [WORD_WIDTH-1:0] xor_q, xor_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [WORD_WIDTH-1:0] src_sh_q, batt_sh_q, val_sh_q, clu_sh_q, dst_sh_q, chk_q;
  logic [WORD_WIDTH-1:0] src_q, batt_q, val_q, clu_q, dst_q;
  logic [CNT_WIDTH-1:0]  ok_q, bad_q;
  logic                  xfer, frame_pass, ok_inc, bad_inc;
  logic                  rx_ready, en;

  assign xfer       = bus.rx_valid && rx_ready;
  assign frame_pass = (chk_q == xor_q) && (clu_sh_q == MyCluster);

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    gap_d   = gap_q;
    ok_inc  = 1'b0;
    bad_inc = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (xfer && (bus.rx_data == SYNC_WORD)) begin
          state_d = StFields;
          idx_d   = '0;
          xor_d   = '0;
          gap_d   = '0;
        end
      end
      StFields: begin
        if (xfer) begin
          gap_d = '0;
          if (idx_q == ChkIdx) begin
            state_d = StCheck;
          end else begin
            idx_d = idx_q + 3'd1;
            xor_d = xor_q ^ bus.rx_data;
          end
        end else if (gap_q == GapLast) begin
          // This idle cycle is the TIMEOUT-th in a row
          state_d = StHunt;
          bad_inc = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StCheck: begin
        if (frame_pass) begin
          state_d = StIssue;
        end else begin
          state_d = StHunt;
          bad_inc = 1'b1;
        end
      end
      StIssue: begin
        // done_reward is not looked at here, so a level left high by the previous
        // frame cannot end this one early
        state_d = StWaitDone;
        ok_inc  = 1'b1;
      end
      StWaitDone: begin
        if (bus.done_reward) begin
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // Outputs; live_q keeps rx_ready low until the first edge after reset
  always_comb begin
    rx_ready = live_q && ((state_q == StHunt) || (state_q == StFields));
    en       = (state_q == StIssue);
  end

  // Datapath: shadow fields, latched outputs, counters
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      live_q    <= 1'b0;
      idx_q     <= '0;
      xor_q     <= '0;
      gap_q     <= '0;
      src_sh_q  <= '0;
      batt_sh_q <= '0;
      val_sh_q  <= '0;
      clu_sh_q  <= '0;
      dst_sh_q  <= '0;
      chk_q     <= '0;
      src_q     <= '0;
      batt_q    <= '0;
      val_q     <= '0;
      clu_q     <= '0;
      dst_q     <= '0;
      ok_q      <= '0;
      bad_q     <= '0;
    end else begin
      live_q <= 1'b1;
      idx_q  <= idx_d;
      xor_q  <= xor_d;
      gap_q  <= gap_d;
      if ((state_q == StFields) && xfer) begin
        case (idx_q)
          3'd0:    src_sh_q  <= bus.rx_data;
          3'd1:    batt_sh_q <= bus.rx_data;
          3'd2:    val_sh_q  <= bus.rx_data;
          3'd3:    clu_sh_q  <= bus.rx_data;
          3'd4:    dst_sh_q  <= bus.rx_data;
          3'd5:    chk_q     <= bus.rx_data;
          default: ;
        endcase
      end
      if ((state_q == StCheck) && frame_pass) begin
        src_q  <= src_sh_q;
        batt_q <= batt_sh_q;
        val_q  <= val_sh_q;
        clu_q  <= clu_sh_q;
        dst_q  <= dst_sh_q;
      end
      if (ok_inc && (ok_q != '1)) begin
        ok_q <= ok_q + CNT_WIDTH'(1);
      end
      if (bad_inc && (bad_q != '1)) begin
        bad_q <= bad_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.rx_ready       = rx_ready;
  assign bus.en             = en;
  assign bus.fsourceID      = src_q;
  assign bus.fbatteryStat   = batt_q;
  assign bus.fValue         = val_q;
  assign bus.fclusterID     = clu_q;
  assign bus.fdestinationID = dst_q;
  assign bus.frames_ok      = ok_q;
  assign bus.frames_bad     = bad_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: directed scenarios plus randomized frames
// checked against a frame-level reference model (checksum/cluster rule, saturating counts).
module tb_rx_frame_parser;
  localparam int unsigned W       = 16;
  localparam int unsigned C       = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [15:0] SYNC    = 16'hA5A5;

  typedef logic [15:0]      word_t;
  typedef logic [6:0][15:0] frame_t;  // [0]=SYNC, [1..5]=fields, [6]=chk

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   en_count = 0;

  // Reference model state
  logic [4:0][15:0] exp_f;
  int               exp_ok;
  int               exp_bad;

  rx_frame_parser_if #(.WORD_WIDTH(W), .CNT_WIDTH(C)) bus ();

  rx_frame_parser #(
    .WORD_WIDTH(W),
    .SYNC_WORD (SYNC),
    .MY_CLUSTER(1),
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (C)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.en === 1'b1) en_count <= en_count + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic frame_t build(input word_t s, input word_t b, input word_t v,
                                   input word_t c, input word_t d, input word_t flip);
    frame_t f;
    f[0] = SYNC;
    f[1] = s; f[2] = b; f[3] = v; f[4] = c; f[5] = d;
    f[6] = s ^ b ^ v ^ c ^ d ^ flip;
    return f;
  endfunction

  function automatic bit frame_good(input frame_t f);
    return (f[6] == (f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5])) && (f[4] == 16'd1);
  endfunction

  function automatic int sat(input int x);
    return (x < 255) ? x + 1 : x;
  endfunction

  task automatic model_apply(input frame_t f);
    if (frame_good(f)) begin
      for (int i = 0; i < 5; i++) exp_f[i] = f[i+1];
      exp_ok = sat(exp_ok);
    end else begin
      exp_bad = sat(exp_bad);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a word and hold it until it transfers; returns at edge+1
  task automatic send_word(input word_t w, output bit ok);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = w;
    while (bus.rx_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    step();
    ok = (n < 300);
  endtask

  task automatic send_frame(input frame_t f, input int stall_at, input int stall_len,
                            output bit ok);
    bit g;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == stall_at && stall_len > 0) begin
        bus.rx_valid = 1'b0;
        repeat (stall_len) @(posedge clock);
        #1;
      end
      send_word(f[i], g);
      ok = ok & g;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    exp_f = '0;
    exp_ok = 0;
    exp_bad = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.done_reward = 1'b1;
    repeat (2) step();
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.en !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: rx_ready=%b en=%b want 0 0", bus.rx_ready, bus.en);
    end
    checks++;
    if ({bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID}
        !== 80'h0) begin
      failures++;
      $display("FAIL reset_fields: got %h %h %h %h %h want 0", bus.fsourceID,
               bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID);
    end
    checks++;
    if (bus.frames_ok !== 8'd0 || bus.frames_bad !== 8'd0) begin
      failures++;
      $display("FAIL reset_counters: ok=%0d bad=%0d want 0 0", bus.frames_ok, bus.frames_bad);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: rx_ready=%b want 0", bus.rx_ready);
    end
    step();
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_edge: rx_ready=%b want 1", bus.rx_ready);
    end
    exp_f = '0;
    exp_ok = 0;
    exp_bad = 0;
  endtask

  task automatic test_good_frame();
    frame_t f;
    bit     ok;
    int     n0;
    do_reset();
    bus.done_reward = 1'b1;
    f = build(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003, 16'h0);
    n0 = en_count;
    send_frame(f, -1, 0, ok);
    model_apply(f);
    checks++;
    if (!ok) begin failures++; $display("FAIL good_send: rx_ready never high"); end
    checks++;
    if (bus.en !== 1'b0) begin failures++; $display("FAIL good_en_early: en=%b want 0", bus.en); end
    step();
    checks++;
    if (bus.en !== 1'b1) begin failures++; $display("FAIL good_en: en=%b want 1", bus.en); end
    checks++;
    if ({bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID}
        !== {16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003}) begin
      failures++;
      $display("FAIL good_fields: got %h %h %h %h %h want 000f 5999 0680 0001 0003",
               bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID,
               bus.fdestinationID);
    end
    step();
    checks++;
    if (bus.en !== 1'b0 || en_count - n0 != 1) begin
      failures++;
      $display("FAIL good_en_pulse: en=%b pulses=%0d want 0 1", bus.en, en_count - n0);
    end
    checks++;
    if (bus.frames_ok !== 8'(exp_ok) || bus.frames_bad !== 8'(exp_bad)) begin
      failures++;
      $display("FAIL good_counters: ok=%0d bad=%0d want %0d %0d", bus.frames_ok,
               bus.frames_bad, exp_ok, exp_bad);
    end
  endtask

  task automatic test_bad_checksum();
    frame_t f;
    bit     ok;
    int     n0;
    do_reset();
    f = build(16'h000F, 16'h5999, 16'h0680, 16'h0001, 16'h0003, 16'h0);
    f[6] = 16'h0000;
    n0 = en_count;
    send_frame(f, -1, 0, ok);
    model_apply(f);
    repeat (3) step();
    checks++;
    if (!ok || en_count != n0) begin
      failures++;
      $display("FAIL badchk_en: send_ok=%b pulses=%0d want 1 0", ok, en_count - n0);
    end
    checks++;
    if (bus.frames_bad !== 8'(exp_bad) || bus.frames_ok !== 8'(exp_ok)) begin
      failures++;
      $display("FAIL badchk_counters: ok=%0d bad=%0d want %0d %0d", bus.frames_ok,
               bus.frames_bad, exp_ok, exp_bad);
    end
    checks++;
    if ({bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID}
        !== {exp_f[0], exp_f[1], exp_f[2], exp_f[3], exp_f[4]}) begin
      failures++;
      $display("FAIL badchk_fields: got %h %h %h %h %h want unchanged", bus.fsourceID,
               bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID);
    end
  endtask

  task automatic test_bad_cluster();
    frame_t f;
    bit     ok;
    int     n0;
    do_reset();
    f = build(word_t'($urandom), word_t'($urandom), word_t'($urandom), 16'd2,
              word_t'($urandom), 16'h0);
    n0 = en_count;
    send_frame(f, -1, 0, ok);
    model_apply(f);
    checks++;
    if (!ok || bus.rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL cluster_check_cycle: send_ok=%b rx_ready=%b want 1 0", ok, bus.rx_ready);
    end
    step();
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL cluster_ready_back: rx_ready=%b want 1", bus.rx_ready);
    end
    step();
    checks++;
    if (bus.frames_bad !== 8'(exp_bad) || en_count != n0) begin
      failures++;
      $display("FAIL cluster_drop: bad=%0d pulses=%0d want %0d 0", bus.frames_bad,
               en_count - n0, exp_bad);
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    bit     ok, g, saw_ready;
    do_reset();
    bus.done_reward = 1'b0;
    send_word(16'h1234, ok);
    send_word(16'h5678, g);
    ok = ok & g;
    f1 = build(word_t'($urandom), word_t'($urandom), word_t'($urandom), 16'd1,
               word_t'($urandom), 16'h0);
    send_frame(f1, -1, 0, g);
    ok = ok & g;
    model_apply(f1);
    repeat (2) step();
    f2 = build(word_t'($urandom), word_t'($urandom), word_t'($urandom), 16'd1,
               word_t'($urandom), 16'h0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = SYNC;
    saw_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rx_ready !== 1'b0) saw_ready = 1'b1;
      step();
    end
    checks++;
    if (saw_ready || bus.frames_ok !== 8'd1) begin
      failures++;
      $display("FAIL b2b_holdoff: saw_ready=%b ok=%0d want 0 1", saw_ready, bus.frames_ok);
    end
    bus.done_reward = 1'b1;
    send_frame(f2, -1, 0, g);
    ok = ok & g;
    model_apply(f2);
    repeat (2) step();
    checks++;
    if (!ok || bus.frames_ok !== 8'(exp_ok) || bus.frames_bad !== 8'(exp_bad)) begin
      failures++;
      $display("FAIL b2b_counters: send_ok=%b ok=%0d bad=%0d want 1 %0d %0d", ok,
               bus.frames_ok, bus.frames_bad, exp_ok, exp_bad);
    end
    checks++;
    if ({bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID}
        !== {exp_f[0], exp_f[1], exp_f[2], exp_f[3], exp_f[4]}) begin
      failures++;
      $display("FAIL b2b_fields: got %h %h %h %h %h want %h %h %h %h %h", bus.fsourceID,
               bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID,
               exp_f[0], exp_f[1], exp_f[2], exp_f[3], exp_f[4]);
    end
  endtask

  task automatic test_timeout();
    frame_t f1, f2, f3;
    bit     ok, g;
    do_reset();
    bus.done_reward = 1'b1;
    // TIMEOUT-1 idle cycles after the batt word must not abort the frame
    f1 = build(16'h0011, 16'h0022, 16'h0033, 16'h0001, 16'h0044, 16'h0);
    send_frame(f1, 3, TIMEOUT - 1, ok);
    model_apply(f1);
    repeat (2) step();
    checks++;
    if (!ok || bus.frames_ok !== 8'(exp_ok) || bus.frames_bad !== 8'(exp_bad)) begin
      failures++;
      $display("FAIL timeout_edge_ok: send_ok=%b ok=%0d bad=%0d want 1 %0d %0d", ok,
               bus.frames_ok, bus.frames_bad, exp_ok, exp_bad);
    end
    f2 = build(16'h0101, 16'h0202, 16'h0303, 16'h0001, 16'h0404, 16'h0);
    for (int i = 0; i < 3; i++) begin
      send_word(f2[i], g);
      ok = ok & g;
    end
    bus.rx_valid = 1'b0;
    repeat (TIMEOUT - 1) step();
    checks++;
    if (bus.frames_bad !== 8'(exp_bad)) begin
      failures++;
      $display("FAIL timeout_early: bad=%0d want %0d", bus.frames_bad, exp_bad);
    end
    step();
    exp_bad = sat(exp_bad);
    checks++;
    if (!ok || bus.frames_bad !== 8'(exp_bad) || bus.rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_drop: send_ok=%b bad=%0d rx_ready=%b want 1 %0d 1", ok,
               bus.frames_bad, bus.rx_ready, exp_bad);
    end
    f3 = build(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0001, 16'h0D0D, 16'h0);
    send_frame(f3, -1, 0, ok);
    model_apply(f3);
    repeat (2) step();
    checks++;
    if (!ok || bus.frames_ok !== 8'(exp_ok) || bus.fValue !== 16'h0C0C) begin
      failures++;
      $display("FAIL timeout_recover: send_ok=%b ok=%0d value=%h want 1 %0d 0c0c", ok,
               bus.frames_ok, bus.fValue, exp_ok);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_t f1, f2, f3;
    bit     ok, g;
    do_reset();
    bus.done_reward = 1'b1;
    f1 = build(16'h1111, 16'h2222, 16'h3333, 16'h0001, 16'h4444, 16'h0);
    send_frame(f1, -1, 0, ok);
    repeat (2) step();
    f2 = build(16'h5555, 16'h6666, 16'h7777, 16'h0001, 16'h8888, 16'h0);
    for (int i = 0; i < 4; i++) begin
      send_word(f2[i], g);
      ok = ok & g;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.en !== 1'b0 || bus.frames_ok !== 8'd0 ||
        bus.frames_bad !== 8'd0) begin
      failures++;
      $display("FAIL async_reset_ctl: rx_ready=%b en=%b ok=%0d bad=%0d want 0 0 0 0",
               bus.rx_ready, bus.en, bus.frames_ok, bus.frames_bad);
    end
    checks++;
    if ({bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID}
        !== 80'h0) begin
      failures++;
      $display("FAIL async_reset_fields: got %h %h %h %h %h want 0", bus.fsourceID,
               bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID);
    end
    bus.rx_valid = 1'b0;
    step();
    rst = 1'b0;
    exp_f = '0;
    exp_ok = 0;
    exp_bad = 0;
    f3 = build(16'h0ABC, 16'h0DEF, 16'h0123, 16'h0001, 16'h0456, 16'h0);
    send_frame(f3, -1, 0, g);
    ok = ok & g;
    model_apply(f3);
    repeat (2) step();
    checks++;
    if (!ok || bus.frames_ok !== 8'd1 || bus.frames_bad !== 8'd0 || bus.fsourceID !== 16'h0ABC)
    begin
      failures++;
      $display("FAIL after_reset_frame: send_ok=%b ok=%0d bad=%0d src=%h want 1 1 0 0abc", ok,
               bus.frames_ok, bus.frames_bad, bus.fsourceID);
    end
  endtask

  task automatic test_random();
    frame_t f;
    word_t  w, c, flip;
    bit     ok, g, good;
    int     n0, kind;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      ok = 1'b1;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        w = word_t'($urandom);
        if (w == SYNC) w = w ^ 16'h1;
        send_word(w, g);
        ok = ok & g;
      end
      kind = int'($urandom_range(0, 3));
      c = 16'd1;
      if (kind == 3) begin
        c = word_t'($urandom);
        if (c == 16'd1) c = 16'd0;
      end
      flip = (kind == 2) ? word_t'($urandom_range(1, 65535)) : 16'h0;
      f = build(word_t'($urandom), word_t'($urandom), word_t'($urandom), c,
                word_t'($urandom), flip);
      good = frame_good(f);
      bus.done_reward = 1'($urandom_range(0, 1));
      n0 = en_count;
      send_frame(f, int'($urandom_range(1, 6)), int'($urandom_range(0, 8)), g);
      ok = ok & g;
      model_apply(f);
      checks++;
      if (!ok || bus.en !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_check_cycle: send_ok=%b en=%b want 1 0", k, ok, bus.en);
      end
      step();
      checks++;
      if (bus.en !== good) begin
        failures++;
        $display("FAIL rnd%0d_en: en=%b want %b", k, bus.en, good);
      end
      checks++;
      if ({bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID, bus.fdestinationID}
          !== {exp_f[0], exp_f[1], exp_f[2], exp_f[3], exp_f[4]}) begin
        failures++;
        $display("FAIL rnd%0d_fields: got %h %h %h %h %h want %h %h %h %h %h", k,
                 bus.fsourceID, bus.fbatteryStat, bus.fValue, bus.fclusterID,
                 bus.fdestinationID, exp_f[0], exp_f[1], exp_f[2], exp_f[3], exp_f[4]);
      end
      step();
      checks++;
      if (bus.frames_ok !== 8'(exp_ok) || bus.frames_bad !== 8'(exp_bad) ||
          en_count - n0 != int'(good)) begin
        failures++;
        $display("FAIL rnd%0d_counters: ok=%0d bad=%0d pulses=%0d want %0d %0d %0d", k,
                 bus.frames_ok, bus.frames_bad, en_count - n0, exp_ok, exp_bad, int'(good));
      end
      repeat ($urandom_range(0, 3)) step();
      bus.done_reward = 1'b1;
      step();
    end
  endtask

  task automatic test_saturation();
    frame_t f;
    bit     ok, g;
    do_reset();
    bus.done_reward = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 258; k++) begin
      f = build(word_t'(k), 16'h0002, 16'h0003, 16'h0001, 16'h0005, 16'h0);
      send_frame(f, -1, 0, g);
      ok = ok & g;
      model_apply(f);
      f = build(word_t'(k), 16'h0002, 16'h0003, 16'h0001, 16'h0005, 16'h8000);
      send_frame(f, -1, 0, g);
      ok = ok & g;
      model_apply(f);
    end
    repeat (3) step();
    checks++;
    if (!ok || bus.frames_ok !== 8'(exp_ok) || bus.frames_bad !== 8'(exp_bad)) begin
      failures++;
      $display("FAIL saturation: send_ok=%b ok=%0d bad=%0d want 1 %0d %0d", ok,
               bus.frames_ok, bus.frames_bad, exp_ok, exp_bad);
    end
    checks++;
    if (bus.fsourceID !== 16'd257) begin
      failures++;
      $display("FAIL saturation_fields: src=%h want 0101", bus.fsourceID);
    end
  endtask

  initial begin
    bus.rx_valid    = 1'b0;
    bus.rx_data     = '0;
    bus.done_reward = 1'b1;
    exp_f   = '0;
    exp_ok  = 0;
    exp_bad = 0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_cluster();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
